// File: rtl/noc_vc_pkg.sv
// Shared types and constants for the VC output credit controller.
package noc_vc_pkg;

  localparam int unsigned FT_HOF = 0;
  localparam int unsigned FT_BOF = 1;
  localparam int unsigned FT_EOF = 2;

  typedef enum logic {
    IDLE = 1'b0,
    PKT  = 1'b1
  } vc_state_e;

  // Width needed to hold 0..bd credits inclusive.
  function automatic int unsigned crd_w(input int unsigned bd);
    return $clog2(bd + 1);
  endfunction

endpackage

// File: rtl/vc_out_credit_ctl_rr_arb.sv
// Round-robin arbiter: grants the first request at or after the pointer.
// The pointer moves to just past the winner, and only when a grant is issued.
module rr_arb #(
  parameter int unsigned N = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req_i,
  output logic [N-1:0] gnt_o
);

  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q, ptr_d;
  logic [N-1:0]  mask;
  logic [N-1:0]  hi_req;
  logic [N-1:0]  pick;

  // Requests at or above the pointer win first; otherwise wrap to the bottom.
  always_comb begin
    mask   = '0;
    for (int unsigned j = 0; j < N; j++) begin
      mask[j] = (j >= 32'(ptr_q));
    end
    hi_req = req_i & mask;
    pick   = (hi_req != '0) ? hi_req : req_i;
    gnt_o  = '0;
    ptr_d  = ptr_q;
    for (int unsigned j = 0; j < N; j++) begin
      if (pick[j] && (gnt_o == '0)) begin
        gnt_o[j] = 1'b1;
        ptr_d    = (j == N - 1) ? '0 : PW'(j + 1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/vc_out_credit_ctl.sv
// Credit-based VC output port: per-VC credits, framing FSMs, RR arbitration, output register.
// Optional checker build: define VC_CREDIT_CHK_EN to add the sticky err output and assertions.
module vc_out_credit_ctl
  import noc_vc_pkg::*;
#(
  parameter int unsigned DW  = 32,
  parameter int unsigned VCN = 2,
  parameter int unsigned FT  = 3,
  parameter int unsigned BD  = 4,
  localparam int unsigned CW = crd_w(BD)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [VCN*DW-1:0]  vi_data,
  input  logic [VCN*FT-1:0]  vi_ft,
  input  logic [VCN-1:0]     vi_valid,
  output logic [VCN-1:0]     vi_ready,
  output logic [DW-1:0]      do_data,
  output logic [FT-1:0]      do_ft,
  output logic [VCN-1:0]     do_vc,
  output logic               do_valid,
  input  logic [VCN-1:0]     cr_in,
  output logic [VCN*CW-1:0]  crd_cnt
`ifdef VC_CREDIT_CHK_EN
  ,
  output logic               err
`endif
);

  logic [CW-1:0] crd_q [VCN];
  logic [CW-1:0] crd_d [VCN];
  vc_state_e     st_q  [VCN];
  vc_state_e     st_d  [VCN];

  logic [VCN-1:0] elig;
  logic [VCN-1:0] gnt;
  logic [DW-1:0]  sel_data;
  logic [FT-1:0]  sel_ft;

  logic [DW-1:0]  do_data_q;
  logic [FT-1:0]  do_ft_q;
  logic [VCN-1:0] do_vc_q;
  logic           do_valid_q;

  always_comb begin
    for (int unsigned v = 0; v < VCN; v++) begin
      elig[v] = vi_valid[v] && (crd_q[v] != '0);
    end
  end

  rr_arb #(
    .N (VCN)
  ) u_arb (
    .clk   (clk),
    .rst   (rst),
    .req_i (elig),
    .gnt_o (gnt)
  );

  assign vi_ready = rst ? '0 : gnt;

  // Mux the granted VC's head flit toward the output register.
  always_comb begin
    sel_data = '0;
    sel_ft   = '0;
    for (int unsigned v = 0; v < VCN; v++) begin
      if (gnt[v]) begin
        sel_data = vi_data[v*DW +: DW];
        sel_ft   = vi_ft[v*FT +: FT];
      end
    end
  end

  // Credit counters: a simultaneous grant and return cancel; returns saturate at BD.
  always_comb begin
    for (int unsigned v = 0; v < VCN; v++) begin
      crd_d[v] = crd_q[v];
      if (gnt[v] && !cr_in[v]) begin
        crd_d[v] = crd_q[v] - CW'(1);
      end else if (!gnt[v] && cr_in[v] && (crd_q[v] != CW'(BD))) begin
        crd_d[v] = crd_q[v] + CW'(1);
      end
    end
  end

  // Per-VC framing state, advanced only by that VC's granted flits.
  always_comb begin
    for (int unsigned v = 0; v < VCN; v++) begin
      st_d[v] = st_q[v];
      if (gnt[v]) begin
        case (st_q[v])
          IDLE:    if (vi_ft[v*FT + FT_HOF] && !vi_ft[v*FT + FT_EOF]) st_d[v] = PKT;
          PKT:     if (vi_ft[v*FT + FT_EOF]) st_d[v] = IDLE;
          default: st_d[v] = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned v = 0; v < VCN; v++) begin
        crd_q[v] <= CW'(BD);
        st_q[v]  <= IDLE;
      end
      do_data_q  <= '0;
      do_ft_q    <= '0;
      do_vc_q    <= '0;
      do_valid_q <= 1'b0;
    end else begin
      for (int unsigned v = 0; v < VCN; v++) begin
        crd_q[v] <= crd_d[v];
        st_q[v]  <= st_d[v];
      end
      do_valid_q <= (gnt != '0);
      if (gnt != '0) begin
        do_data_q <= sel_data;
        do_ft_q   <= sel_ft;
        do_vc_q   <= gnt;
      end
    end
  end

  always_comb begin
    for (int unsigned v = 0; v < VCN; v++) begin
      crd_cnt[v*CW +: CW] = crd_q[v];
    end
  end

  assign do_data  = do_data_q;
  assign do_ft    = do_ft_q;
  assign do_vc    = do_vc_q;
  assign do_valid = do_valid_q;

`ifdef VC_CREDIT_CHK_EN
  logic err_q, err_d;
  logic ovf, bad_idle, bad_pkt, bad_code;

  // Protocol violations seen this cycle; err latches any of them until reset.
  always_comb begin
    ovf      = 1'b0;
    bad_idle = 1'b0;
    bad_pkt  = 1'b0;
    bad_code = 1'b0;
    for (int unsigned v = 0; v < VCN; v++) begin
      if (cr_in[v] && (crd_q[v] == CW'(BD))) ovf = 1'b1;
      if (gnt[v] && (st_q[v] == IDLE) && !vi_ft[v*FT + FT_HOF] &&
          (vi_ft[v*FT + FT_BOF] || vi_ft[v*FT + FT_EOF])) bad_idle = 1'b1;
      if (gnt[v] && (st_q[v] == PKT) && vi_ft[v*FT + FT_HOF]) bad_pkt = 1'b1;
    end
    if ((gnt != '0) && ((sel_ft == '0) || ((sel_ft & (sel_ft - FT'(1))) != '0))) begin
      bad_code = 1'b1;
    end
    err_d = err_q | ovf | bad_idle | bad_pkt | bad_code;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;

  a_ready_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(vi_ready));
  a_no_ovf:        assert property (@(posedge clk) disable iff (rst) !ovf)
    else $warning("credit return at full credit");
  a_idle_frame:    assert property (@(posedge clk) disable iff (rst) !bad_idle)
    else $warning("body/tail flit granted outside a packet");
  a_pkt_frame:     assert property (@(posedge clk) disable iff (rst) !bad_pkt)
    else $warning("head flit granted inside a packet");
  a_ft_code:       assert property (@(posedge clk) disable iff (rst) !bad_code)
    else $warning("flit type not one-hot on grant");
`endif

endmodule

// File: tb/tb_vc_out_credit_ctl.sv
// Randomized self-checking bench for vc_out_credit_ctl against a cycle-level reference model.
module tb_vc_out_credit_ctl;

  localparam int unsigned DW  = 32;
  localparam int unsigned VCN = 2;
  localparam int unsigned FT  = 3;
  localparam int unsigned BD  = 4;
  localparam int unsigned CW  = $clog2(BD + 1);

  logic              clk = 1'b0;
  logic              rst;
  logic [VCN*DW-1:0] vi_data;
  logic [VCN*FT-1:0] vi_ft;
  logic [VCN-1:0]    vi_valid;
  logic [VCN-1:0]    vi_ready;
  logic [DW-1:0]     do_data;
  logic [FT-1:0]     do_ft;
  logic [VCN-1:0]    do_vc;
  logic              do_valid;
  logic [VCN-1:0]    cr_in;
  logic [VCN*CW-1:0] crd_cnt;
`ifdef VC_CREDIT_CHK_EN
  logic              err;
`endif

  always #5 clk = ~clk;

  vc_out_credit_ctl #(
    .DW (DW), .VCN (VCN), .FT (FT), .BD (BD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .vi_data  (vi_data),
    .vi_ft    (vi_ft),
    .vi_valid (vi_valid),
    .vi_ready (vi_ready),
    .do_data  (do_data),
    .do_ft    (do_ft),
    .do_vc    (do_vc),
    .do_valid (do_valid),
    .cr_in    (cr_in),
    .crd_cnt  (crd_cnt)
`ifdef VC_CREDIT_CHK_EN
    ,
    .err      (err)
`endif
  );

  int unsigned vec_cnt = 0;
  int unsigned miscmp  = 0;

  // Reference model state
  int             m_crd [VCN];
  int             m_next;
  int             m_pkt [VCN];
  logic           m_dv;
  logic [DW-1:0]  m_dd;
  logic [FT-1:0]  m_dft;
  logic [VCN-1:0] m_dvc;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miscmp++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [VCN-1:0] model_grant();
    logic [VCN-1:0] g;
    int v;
    g = '0;
    if (rst) return g;
    for (int i = 0; i < VCN; i++) begin
      v = (m_next + i) % VCN;
      if (vi_valid[v] && (m_crd[v] > 0)) begin
        g[v] = 1'b1;
        return g;
      end
    end
    return g;
  endfunction

  task automatic model_reset();
    for (int v = 0; v < VCN; v++) begin
      m_crd[v] = BD;
      m_pkt[v] = 0;
    end
    m_next = 0;
    m_dv   = 1'b0;
    m_dd   = '0;
    m_dft  = '0;
    m_dvc  = '0;
  endtask

  // One clock: check combinational/pre-edge outputs, advance the model, check registered outputs.
  task automatic cycle();
    logic [VCN-1:0] g;
    logic [FT-1:0]  ft;
    @(negedge clk);
    g = model_grant();
    check("vi_ready", 64'(vi_ready), 64'(g));
    for (int v = 0; v < VCN; v++) check("crd_cnt", 64'(crd_cnt[v*CW +: CW]), 64'(m_crd[v]));
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      m_dv = (g != '0);
      for (int v = 0; v < VCN; v++) begin
        if (g[v]) begin
          ft     = vi_ft[v*FT +: FT];
          m_dd   = vi_data[v*DW +: DW];
          m_dft  = ft;
          m_dvc  = g;
          m_next = (v + 1) % VCN;
          if (ft[2]) m_pkt[v] = 0;
          else if (ft[0]) m_pkt[v] = 1;
        end
        if (g[v] && !cr_in[v]) m_crd[v] = m_crd[v] - 1;
        else if (!g[v] && cr_in[v] && (m_crd[v] < BD)) m_crd[v] = m_crd[v] + 1;
      end
    end
    #1;
    check("do_valid", 64'(do_valid), 64'(m_dv));
    check("do_vc",    64'(do_vc),    64'(m_dvc));
    check("do_data",  64'(do_data),  64'(m_dd));
    check("do_ft",    64'(do_ft),    64'(m_dft));
  endtask

  // Well-formed stimulus: HOF when idle, then BOF/EOF until the packet ends.
  task automatic drive(input logic [VCN-1:0] vld, input logic [VCN-1:0] cr);
    vi_valid = vld;
    cr_in    = cr;
    for (int v = 0; v < VCN; v++) begin
      vi_data[v*DW +: DW] = $urandom;
      if (m_pkt[v] != 0) vi_ft[v*FT +: FT] = ($urandom_range(0, 1) != 0) ? 3'b100 : 3'b010;
      else               vi_ft[v*FT +: FT] = 3'b001;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive('0, '0);
    cycle();
    rst = 1'b0;
  endtask

  logic [VCN-1:0] exp_vc [4];
  logic [VCN-1:0] cr_r;
  logic [VCN-1:0] vld_r;

  initial begin
    exp_vc[0] = 2'b01; exp_vc[1] = 2'b10; exp_vc[2] = 2'b01; exp_vc[3] = 2'b10;
    model_reset();
    rst = 1'b1;
    drive('0, '0);
    @(posedge clk);
    #1;

    // Reset state
    cycle();
    check("rst_crd0", 64'(crd_cnt[0 +: CW]), 64'(BD));
    check("rst_crd1", 64'(crd_cnt[CW +: CW]), 64'(BD));
    check("rst_ready", 64'(vi_ready), 64'(0));
    rst = 1'b0;

    // VC0 streams until out of credit, then one returned credit frees one flit
    for (int i = 0; i < 6; i++) begin
      drive(2'b01, 2'b00);
      cycle();
    end
    check("t2_blocked_crd", 64'(crd_cnt[0 +: CW]), 64'(0));
    check("t2_blocked_valid", 64'(do_valid), 64'(0));
    drive(2'b01, 2'b01);
    cycle();
    drive(2'b01, 2'b00);
    cycle();
    check("t2_fifth_flit", 64'(do_valid), 64'(1));
    for (int i = 0; i < 4; i++) begin
      drive(2'b00, 2'b01);
      cycle();
    end

    // Both VCs eligible: strict alternation starting at VC0
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(2'b11, 2'b00);
      cycle();
      check("t3_alt_vc", 64'(do_vc), 64'(exp_vc[i]));
    end

    // Grant and credit return on VC1 in the same cycle at credit 2
    check("t4_pre_crd1", 64'(crd_cnt[CW +: CW]), 64'(2));
    drive(2'b10, 2'b10);
    cycle();
    check("t4_crd1_held", 64'(crd_cnt[CW +: CW]), 64'(2));
    check("t4_flit", 64'(do_vc), 64'(2'b10));

    // Reset while VC0 is mid-packet with one credit left
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(2'b01, 2'b00);
      cycle();
    end
    check("t6_pre_crd0", 64'(crd_cnt[0 +: CW]), 64'(1));
    rst = 1'b1;
    drive(2'b01, 2'b00);
    cycle();
    rst = 1'b0;
    check("t6_crd0", 64'(crd_cnt[0 +: CW]), 64'(BD));
    check("t6_valid", 64'(do_valid), 64'(0));
    drive(2'b01, 2'b00);
    cycle();
    check("t6_restart_ft", 64'(do_ft), 64'(3'b001));

`ifdef VC_CREDIT_CHK_EN
    // Sticky error on credit overflow and on a body flit outside a packet
    do_reset();
    check("t5_err_rst", 64'(err), 64'(0));
    drive(2'b00, 2'b01);
    cycle();
    check("t5_ovf_crd", 64'(crd_cnt[0 +: CW]), 64'(BD));
    check("t5_ovf_err", 64'(err), 64'(1));
    drive(2'b00, 2'b00);
    cycle();
    cycle();
    check("t5_err_sticky", 64'(err), 64'(1));
    do_reset();
    check("t5_err_clr", 64'(err), 64'(0));
    drive(2'b01, 2'b00);
    vi_ft[0 +: FT] = 3'b010;
    cycle();
    check("t5_bof_err", 64'(err), 64'(1));
    do_reset();
`endif

    // Randomized traffic with realistic credit returns and occasional resets
    for (int i = 0; i < 2000; i++) begin
      vld_r = VCN'($urandom);
      for (int v = 0; v < VCN; v++) begin
        cr_r[v] = (m_crd[v] < BD) && ($urandom_range(0, 2) == 0);
      end
      rst = ($urandom_range(0, 199) == 0);
      drive(vld_r, cr_r);
      cycle();
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp);
    $finish;
  end

endmodule
